imem_fetch_arbiter: RTL and testbench
=====================================

Name: imem_fetch_arbiter

Overview:
Sequences a single-port, byte-wide, synchronous-read instruction RAM for the Y86-64 fetch stage and shares it with a program-loader write port. A fetch is an atomic multi-cycle burst whose length comes from the icode in byte 0. It returns Byte0 plus a 72-bit Byte19 field, zero-padded, with imem_error. Loader writes are granted only between fetch bursts.

Parameters:
MEM_BYTES, 2048, RAM depth in bytes; legal addresses are 0..MEM_BYTES-1
ADDR_W, 11, RAM address width (clog2 of MEM_BYTES)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
fetch_req  in  1  fetch request; held until accepted
fetch_pc  in  64  byte address of the instruction
fetch_ready  out  1  arbiter can accept a fetch this cycle
fetch_valid  out  1  one-cycle pulse: results below are valid
Byte0  out  8  icode:ifun byte
Byte19  out  72  bytes pc+1..pc+9; [7:0]=pc+1; unused bytes are 0
imem_error  out  1  pc, or any byte of the instruction, lies outside 0..MEM_BYTES-1
ld_valid  in  1  loader write request
ld_addr  in  ADDR_W  loader byte address
ld_data  in  8  loader byte
ld_ready  out  1  loader write accepted this cycle
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Clocking and reset: single clk domain; rst_n asynchronous, active-low.
- During reset every output is 0 except fetch_ready, which follows the grant logic. Reset mid-burst aborts the burst and produces no fetch_valid.
- FSM states are IDLE, ISSUE, STREAM, DONE, ERR.
- Acceptance, IDLE only:
  - fetch_ready = (state==IDLE) && !loader_wins.
  - ld_ready = (state==IDLE) && ld_valid && loader_wins.
  - Default arbitration is fixed priority: loader_wins = ld_valid.
- Loader write: on the accept cycle, mem_en, mem_we, mem_addr and mem_wdata are registered. The write occurs in the next cycle. State stays IDLE.
- Fetch accept in cycle A with fetch_pc > MEM_BYTES-1: go to ERR. No RAM access. In cycle A+1: fetch_valid=1, imem_error=1, Byte0=0, Byte19=0. Then IDLE.
- Fetch accept in cycle A otherwise: the pc is latched and the FSM goes to ISSUE.
  - Byte k (k=0..L-1) is read-issued in cycle A+1+k; byte 1 is issued speculatively in A+2.
  - Byte k is captured from mem_rdata in cycle A+2+k.
  - L is decoded from mem_rdata[7:4] in cycle A+2:
    - icode 0, 1, 9 -> L=1
    - icode 2, 6, A, B -> L=2
    - icode 3, 4, 5 -> L=10
    - icode 7, 8 -> L=9
    - icode C..F -> L=1, and the FSM still completes normally.
  - fetch_valid pulses in cycle A+2+L. The FSM returns to IDLE in that same cycle.
  - Outputs hold until the next fetch_valid.
- Range boundary: if pc+L-1 > MEM_BYTES-1, bytes past the last address are not read. They return 0, and imem_error=1 with fetch_valid.
  - Address arithmetic is 64-bit with no wrap: pc=MEM_BYTES-1 with L=2 is an error.
- The burst is atomic. ld_ready=0 from A through A+2+L inclusive.
- Simultaneous ld_valid and fetch_req in IDLE: the loader is served (default). Fetch is accepted in the first IDLE cycle with ld_valid=0.
- mem_we=1 only on loader writes. mem_en=0 in any cycle with no access.

Optional Feature:
IMEM_RR_ARB_EN:
- Defined: round-robin arbitration. A 1-bit last_grant register is reset to 0 (fetch). When both requesters are pending in IDLE, the requester not granted last wins.
- Undefined: fixed loader priority. A continuous ld_valid starves fetch, and this is legal.

Decomposition:
- Shared package imem_pkg holds:
  - icode constants: HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B
  - MEM_BYTES
  - the FSM state enum
- One sub-module, imem_ilen_decode: combinational icode -> length (4-bit). Reused by decode.

Test Plan:
- Reset, then fetch pc=0 on RAM byte 0x10 -> fetch_valid in cycle A+3; Byte0=0x10, Byte19=0, imem_error=0.
- Fetch pc=1 on irmovq bytes 30 F8 0A 00.. -> fetch_valid in cycle A+12; Byte0=0x30, Byte19[15:0]=0x0AF8, remaining bytes 0.
- Fetch pc=2047 on byte 0x30 -> fetch_valid with Byte0=0x30, Byte19=0, imem_error=1; no mem_addr beyond 2047. Fetch pc=4096 -> fetch_valid in cycle A+1, Byte0=0, imem_error=1, mem_en never asserted.
- ld_valid and fetch_req both high in IDLE, ld_addr=0x70, ld_data=0x90 -> loader granted first. The write appears with mem_we=1 the next cycle. The fetch is accepted afterwards; with IMEM_RR_ARB_EN defined, alternation is observed instead.
- ld_valid raised mid 10-byte burst -> ld_ready stays 0 until the burst's fetch_valid cycle has passed.
- rst_n dropped in cycle A+5 of a burst -> outputs 0 immediately, no fetch_valid; after release, the next fetch completes normally.

Source files
------------

// File: rtl/imem_pkg.sv
// Purpose: shared Y86-64 icode constants, RAM geometry and fetch FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

    localparam int MEM_BYTES = 2048;
    localparam int ADDR_W    = $clog2(MEM_BYTES);

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        STREAM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_ilen_decode.sv
// Purpose: map a Y86-64 icode to its instruction length in bytes (1..10).
// Latency: combinational.
// Backpressure: none.
// Ports: icode (instruction byte [7:4]) in, len (byte count) out.
// Unassigned icodes C..F decode as length 1 so a fetch of garbage still terminates.
module imem_ilen_decode
    import imem_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len
);

    always_comb begin
        len = 4'd1;
        case (icode)
            HALT, NOP, RET:               len = 4'd1;
            RRMOVQ, OPQ, PUSHQ, POPQ:     len = 4'd2;
            IRMOVQ, RMMOVQ, MRMOVQ:       len = 4'd10;
            JXX, CALL:                    len = 4'd9;
            default:                      len = 4'd1;
        endcase
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Purpose: sequence a byte-wide sync-read instruction RAM for Y86-64 fetch bursts, shared with a loader write port.
// Latency: fetch_valid L+2 cycles after accept (L = instruction length), 1 cycle for an out-of-range pc; loader write 1 cycle.
// Backpressure: fetch_ready/ld_ready only in IDLE; a burst is atomic, loader waits until it ends.
//
// Ports: clk, rst_n (async, active-low); fetch_req/fetch_pc/fetch_ready accept a fetch;
// fetch_valid pulses with Byte0, Byte19 (bytes pc+1..pc+9, zero-padded) and imem_error;
// ld_valid/ld_addr/ld_data/ld_ready form the loader write port; mem_* drive the RAM.
// Build option: define IMEM_RR_ARB_EN for round-robin loader/fetch arbitration
// (default is fixed loader priority, which may starve fetch).
module imem_fetch_arbiter #(
    parameter int MEM_BYTES = imem_pkg::MEM_BYTES,
    parameter int ADDR_W    = imem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [63:0]       fetch_pc,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [7:0]        Byte0,
    output logic [71:0]       Byte19,
    output logic              imem_error,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    import imem_pkg::*;

    // Extra headroom so pc + 15 never wraps while checking the RAM bound.
    localparam int                EXT_W  = ADDR_W + 4;
    localparam logic [EXT_W-1:0]  LAST   = EXT_W'(MEM_BYTES - 1);
    localparam logic [63:0]       LAST64 = 64'(MEM_BYTES - 1);

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [3:0]        idx_q;      // index of the byte currently on mem_rdata
    logic [3:0]        len_q;
    logic [7:0]        b0_stg;
    logic [71:0]       b19_stg;

    logic              loader_wins;
    logic [3:0]        dec_len;
    logic [3:0]        cur_len;
    logic [EXT_W-1:0]  pc_ext;
    logic [EXT_W-1:0]  cur_addr;
    logic [EXT_W-1:0]  nxt_addr;
    logic [EXT_W-1:0]  end_addr;
    logic [7:0]        cur_byte;
    logic              issue_nxt;
    logic              last_byte;
    logic              err_range;
    logic [7:0]        b0_nxt;
    logic [71:0]       b19_nxt;

`ifdef IMEM_RR_ARB_EN
    logic last_grant;   // 1: loader was granted last, 0: fetch
    assign loader_wins = ld_valid && (!fetch_req || !last_grant);
`else
    assign loader_wins = ld_valid;
`endif

    assign fetch_ready = (state == IDLE) && !loader_wins;
    assign ld_ready    = (state == IDLE) && ld_valid && loader_wins;

    imem_ilen_decode u_ilen (
        .icode (mem_rdata[7:4]),
        .len   (dec_len)
    );

    // Byte 0 arrives together with its own length; later bytes use the latched one.
    assign cur_len   = (idx_q == 4'd0) ? dec_len : len_q;
    assign pc_ext    = EXT_W'(pc_q);
    assign cur_addr  = pc_ext + EXT_W'(idx_q);
    assign nxt_addr  = cur_addr + EXT_W'(2);
    assign end_addr  = pc_ext + EXT_W'(cur_len) - EXT_W'(1);
    // Bytes past the end of RAM were never read; force them to zero.
    assign cur_byte  = (cur_addr <= LAST) ? mem_rdata : 8'h00;
    assign issue_nxt = ((5'(idx_q) + 5'd2) < 5'(cur_len)) && (nxt_addr <= LAST);
    assign last_byte = (idx_q == (cur_len - 4'd1));
    assign err_range = (end_addr > LAST);

    always_comb begin
        b0_nxt  = b0_stg;
        b19_nxt = b19_stg;
        if (idx_q == 4'd0) begin
            b0_nxt = cur_byte;
        end
        for (int k = 1; k < 10; k++) begin
            if (idx_q == 4'(k)) begin
                b19_nxt[(k-1)*8 +: 8] = cur_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_q        <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            b0_stg      <= '0;
            b19_stg     <= '0;
            fetch_valid <= 1'b0;
            Byte0       <= '0;
            Byte19      <= '0;
            imem_error  <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
`ifdef IMEM_RR_ARB_EN
            last_grant  <= 1'b0;
`endif
        end else begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            fetch_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_ready) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_data;
`ifdef IMEM_RR_ARB_EN
                        last_grant <= 1'b1;
`endif
                    end else if (fetch_req && fetch_ready) begin
`ifdef IMEM_RR_ARB_EN
                        last_grant <= 1'b0;
`endif
                        if (fetch_pc > LAST64) begin
                            state       <= ERR;
                            fetch_valid <= 1'b1;
                            imem_error  <= 1'b1;
                            Byte0       <= '0;
                            Byte19      <= '0;
                        end else begin
                            state    <= ISSUE;
                            pc_q     <= fetch_pc[ADDR_W-1:0];
                            idx_q    <= '0;
                            b0_stg   <= '0;
                            b19_stg  <= '0;
                            mem_en   <= 1'b1;
                            mem_addr <= fetch_pc[ADDR_W-1:0];
                        end
                    end
                end
                ISSUE: begin
                    // Byte 1 goes out before the length is known.
                    state <= STREAM;
                    if ((pc_ext + EXT_W'(1)) <= LAST) begin
                        mem_en   <= 1'b1;
                        mem_addr <= pc_q + ADDR_W'(1);
                    end
                end
                STREAM: begin
                    b0_stg  <= b0_nxt;
                    b19_stg <= b19_nxt;
                    if (idx_q == 4'd0) begin
                        len_q <= dec_len;
                    end
                    if (last_byte) begin
                        state       <= DONE;
                        fetch_valid <= 1'b1;
                        Byte0       <= b0_nxt;
                        Byte19      <= b19_nxt;
                        imem_error  <= err_range;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                        if (issue_nxt) begin
                            mem_en   <= 1'b1;
                            mem_addr <= nxt_addr[ADDR_W-1:0];
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Purpose: self-checking bench for imem_fetch_arbiter with a behavioural byte RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_imem_fetch_arbiter;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic [63:0]   fetch_pc = '0;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [7:0]    Byte0;
    logic [71:0]   Byte19;
    logic          imem_error;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = '0;
    logic          ld_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;

    imem_fetch_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_pc   (fetch_pc),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .Byte0      (Byte0),
        .Byte19     (Byte19),
        .imem_error (imem_error),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:2047];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [63:0] pc;
        int          lat;
        logic [7:0]  b0;
        logic [71:0] b19;
        logic        err;
        int          reads;
    } vec_t;

    vec_t vecs [10];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Cycle n after the accepting edge is sampled at its falling edge; lat=0 means timeout.
    task automatic do_fetch(input logic [63:0] pc, output int lat, output logic [7:0] b0,
                            output logic [71:0] b19, output logic err, output int reads);
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        lat = 0; reads = 0; b0 = 'x; b19 = 'x; err = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            if (mem_en && !mem_we) reads++;
            if (fetch_valid) begin
                lat = n; b0 = Byte0; b19 = Byte19; err = imem_error;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat, reads, bad, wr;
        logic [7:0]  b0;
        logic [71:0] b19;
        logic        err;

        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
        ram[0] = 8'h10;
        ram[1] = 8'h30; ram[2] = 8'hF8; ram[3] = 8'h0A;
        ram[20] = 8'h20; ram[21] = 8'h12;
        ram[30] = 8'h70;
        for (int i = 0; i < 8; i++) ram[31+i] = 8'(8'h11 * (i + 1));
        ram[39] = 8'hEE;
        ram[50] = 8'hC0; ram[51] = 8'h55;
        ram[2045] = 8'h80; ram[2046] = 8'h20; ram[2047] = 8'h30;

        vecs[0] = '{64'd0,    3,  8'h10, 72'h0,                0, 2};
        vecs[1] = '{64'd1,    12, 8'h30, 72'h0AF8,             0, 10};
        vecs[2] = '{64'd20,   4,  8'h20, 72'h12,               0, 2};
        vecs[3] = '{64'd30,   11, 8'h70, 72'h8877665544332211, 0, 9};
        vecs[4] = '{64'd50,   3,  8'hC0, 72'h0,                0, 2};
        vecs[5] = '{64'd2046, 4,  8'h20, 72'h30,               0, 2};
        vecs[6] = '{64'd2045, 11, 8'h80, 72'h3020,             1, 3};
        vecs[7] = '{64'd2047, 12, 8'h30, 72'h0,                1, 1};
        vecs[8] = '{64'd2048, 1,  8'h00, 72'h0,                1, 0};
        vecs[9] = '{64'd4096, 1,  8'h00, 72'h0,                1, 0};

        // Reset state
        @(negedge clk); #1;
        chk("reset_outputs",
            {fetch_valid, fetch_ready, ld_ready, mem_en, mem_we, imem_error, Byte0, Byte19, mem_addr, mem_wdata},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 72'h0, 11'h000, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven fetches
        for (int i = 0; i < 10; i++) begin
            do_fetch(vecs[i].pc, lat, b0, b19, err, reads);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_byte0", i), b0, vecs[i].b0);
            chk($sformatf("vec%0d_byte19", i), b19, vecs[i].b19);
            chk($sformatf("vec%0d_error", i), err, vecs[i].err);
            chk($sformatf("vec%0d_reads", i), reads, vecs[i].reads);
            @(negedge clk);
            chk($sformatf("vec%0d_hold", i), {fetch_valid, Byte0}, {1'b0, vecs[i].b0});
        end

        // Loader and fetch collide in IDLE
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 11'h070; ld_data = 8'h90;
        fetch_req = 1'b1; fetch_pc = 64'h70;
        #1;
        chk("coll_grant", {ld_ready, fetch_ready}, 2'b10);
        @(negedge clk);
        chk("coll_write", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 11'h070, 8'h90});
        ld_addr = 11'h071; ld_data = 8'h91;
        #1;
`ifdef IMEM_RR_ARB_EN
        chk("coll_rr_alternate", {ld_ready, fetch_ready}, 2'b01);
`else
        chk("coll_fixed_starve", {ld_ready, fetch_ready}, 2'b10);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        chk("coll_fetch_after", {ld_ready, fetch_ready}, 2'b01);
`endif
        @(negedge clk);
        fetch_req = 1'b0;
        ld_valid = 1'b1; ld_addr = 11'h072; ld_data = 8'h92;
        lat = 0; bad = 0; wr = 0; b0 = 'x;
        for (int n = 1; n <= 30; n++) begin
            if (ld_ready) bad++;
            if (mem_we) wr++;
            if (fetch_valid) begin lat = n; b0 = Byte0; break; end
            @(negedge clk);
        end
        chk("coll_fetch_latency", lat, 3);
        chk("coll_fetch_sees_write", b0, 8'h90);
        chk("coll_burst_blocks_ld", {bad, wr}, 64'd0);
        @(negedge clk);
        chk("coll_ld_after_burst", ld_ready, 1'b1);
        @(negedge clk);
        ld_valid = 1'b0;

        // Loader raised during a 10-byte burst
        @(negedge clk);
        fetch_req = 1'b1; fetch_pc = 64'd1;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        lat = 0; bad = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 3) begin ld_valid = 1'b1; ld_addr = 11'h200; ld_data = 8'hAB; #1; end
            if (ld_ready) bad++;
            if (fetch_valid) begin lat = n; break; end
            @(negedge clk);
        end
        chk("mid_burst_latency", lat, 12);
        chk("mid_burst_ld_blocked", bad, 0);
        @(negedge clk);
        chk("mid_burst_ld_after", {ld_ready, fetch_ready}, 2'b10);
        @(negedge clk);
        ld_valid = 1'b0;
        @(negedge clk);
        chk("ld_write_landed", ram[11'h200], 8'hAB);

        // Reset in cycle A+5 of a burst
        fetch_req = 1'b1; fetch_pc = 64'd1;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {fetch_valid, mem_en, mem_we, imem_error, Byte0, Byte19},
            {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 72'h0});
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (fetch_valid) bad++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (fetch_valid) bad++;
        end
        chk("rst_mid_no_valid", bad, 0);
        do_fetch(64'd20, lat, b0, b19, err, reads);
        chk("post_rst_fetch", {lat[7:0], b0, b19, err}, {8'd4, 8'h20, 72'h12, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
